fetch_unit: RTL and testbench

Instruction-fetch front end of the MAIPS pipeline. It owns the architectural fetch PC and issues word requests to the instruction-memory port. It accepts in-order responses into a small PC-tagged buffer and presents one fetched instruction per cycle to the IF/ID pipeline register directly downstream. It handles backpressure from that register's stall, redirects from branch/exception logic, and misaligned-PC faults.

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to the
// instruction memory under a credit limit, and buffers in-order responses
// (tagged with their PC) for the IF/ID register. Redirects flush everything
// and drop any responses still in flight. A misaligned PC produces an AdEL
// entry instead of a request and halts fetch until the next redirect.
module fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] ifq_rd_q, ifq_rd_d;
  logic [PW-1:0] ifq_wr_q, ifq_wr_d;

  logic [31:0] fifo_pc_q    [FIFO_DEPTH];
  logic [31:0] fifo_pc_d    [FIFO_DEPTH];
  logic [31:0] fifo_instr_q [FIFO_DEPTH];
  logic [31:0] fifo_instr_d [FIFO_DEPTH];
  logic        fifo_adel_q  [FIFO_DEPTH];
  logic        fifo_adel_d  [FIFO_DEPTH];
  logic [31:0] ifq_pc_q     [FIFO_DEPTH];
  logic [31:0] ifq_pc_d     [FIFO_DEPTH];

  logic [CW:0] credit_used;
  logic        allowed;
  logic        grant;
  logic        rsp_ok;
  logic        rsp_drop;
  logic        rsp_enq;
  logic        adel_issue;
  logic        pop;
  logic        push;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        push_adel;

  // Issue control and head-of-buffer outputs; credit uses registered counts only.
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
    allowed     = !reset && !halted_q && !redirect_valid && (credit_used < DEPTH_W);
    imem_req    = allowed && (pc_q[1:0] == 2'b00);
    imem_addr   = pc_q;
    grant       = imem_req && imem_gnt;
    rsp_ok      = imem_rvalid && (outstanding_q != '0);
    rsp_drop    = rsp_ok && (drop_q != '0);
    rsp_enq     = rsp_ok && (drop_q == '0);
    adel_issue  = allowed && (pc_q[1:0] != 2'b00) && !rsp_enq;
    out_valid   = (count_q != '0);
    pop         = out_valid && !stall;
    out_pc      = fifo_pc_q[rd_ptr_q];
    out_instr   = fifo_instr_q[rd_ptr_q];
    out_adel    = fifo_adel_q[rd_ptr_q];
  end

  // Next-state for PC, counters, in-flight PC queue and response buffer.
  always_comb begin
    pc_d          = pc_q;
    halted_d      = halted_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_ok);
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    ifq_rd_d      = ifq_rd_q;
    ifq_wr_d      = ifq_wr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
    fifo_adel_d   = fifo_adel_q;
    ifq_pc_d      = ifq_pc_q;
    push          = 1'b0;
    push_pc       = '0;
    push_instr    = '0;
    push_adel     = 1'b0;

    if (grant) begin
      ifq_pc_d[ifq_wr_q] = pc_q;
      ifq_wr_d           = ifq_wr_q + 1'b1;
      pc_d               = pc_q + 32'd4;
    end
    if (rsp_drop) begin
      drop_d = drop_q - 1'b1;
    end
    if (rsp_enq) begin
      push       = 1'b1;
      push_pc    = ifq_pc_q[ifq_rd_q];
      push_instr = imem_rdata;
      ifq_rd_d   = ifq_rd_q + 1'b1;
    end
    if (adel_issue) begin
      push      = 1'b1;
      push_pc   = pc_q;
      push_adel = 1'b1;
      halted_d  = 1'b1;
    end

    if (redirect_valid) begin
      // Everything still in flight after this edge must be discarded, so the
      // drop count is simply the post-update outstanding count.
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      drop_d   = outstanding_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ifq_rd_d = '0;
      ifq_wr_d = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = push_pc;
        fifo_instr_d[wr_ptr_q] = push_instr;
        fifo_adel_d[wr_ptr_q]  = push_adel;
        wr_ptr_d               = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset; all buffer storage cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      halted_q      <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      ifq_rd_q      <= '0;
      ifq_wr_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
        fifo_adel_q[i]  <= 1'b0;
        ifq_pc_q[i]     <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      ifq_rd_q      <= ifq_rd_d;
      ifq_wr_q      <= ifq_wr_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_instr_q  <= fifo_instr_d;
      fifo_adel_q   <= fifo_adel_d;
      ifq_pc_q      <= ifq_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model answers granted requests in order
// after a latency, and a reference model predicts the fetch stream as a
// sequence of PC-tagged entries. Requests issued before a redirect or reset
// belong to an older epoch and must never appear at the output.
module tb_fetch_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_adel;

  fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_adel       (out_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  mreq_t mem_q[$];
  ent_t  mq[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] exp_req_pc = RST_PC;
  bit          halted_m   = 1'b0;
  int unsigned epoch      = 0;
  int unsigned cyc        = 0;
  bit          after_reset = 1'b0;

  bit          k_reset = 1'b1;
  bit          k_stall = 1'b0;
  bit          k_stall_rand = 1'b0;
  bit          k_gnt_rand = 1'b0;
  bit          k_rsp_rand = 1'b0;
  int unsigned k_lat = 1;
  bit          k_redir = 1'b0;
  logic [31:0] k_redir_pc = '0;
  bit          k_redir_rand = 1'b0;
  bit          k_stray = 1'b0;

  logic        s_req, s_valid, s_adel;
  logic [31:0] s_addr, s_pc, s_instr;
  int unsigned dut_grants = 0;
  int unsigned dut_pops   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run_cycle();
    mreq_t       r;
    ent_t        e;
    bit          rsp;
    int unsigned pend;
    int unsigned lat;
    bit          ex_allowed, ex_req, ex_adel;
    logic [31:0] rpc;
    r = '{addr: '0, due: 0, epoch: 0};
    @(posedge clk);
    #1;
    cyc++;
    reset    = k_reset;
    stall    = k_stall_rand ? ($urandom_range(0, 9) < 3) : k_stall;
    imem_gnt = k_gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    lat      = (k_lat == 0) ? $urandom_range(1, 4) : k_lat;

    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (!k_reset) begin
      if (k_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = k_redir_pc;
        k_redir        = 1'b0;
      end else if (k_redir_rand && $urandom_range(0, 29) == 0) begin
        rpc = $urandom;
        case ($urandom_range(0, 9))
          0:       rpc[1:0] = 2'($urandom_range(1, 3));
          1:       rpc = 32'hFFFF_FFF4;
          default: rpc[1:0] = 2'b00;
        endcase
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
    end

    rsp         = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!k_reset && mem_q.size() != 0 && mem_q[0].due <= cyc &&
        (!k_rsp_rand || $urandom_range(0, 3) != 0)) begin
      r           = mem_q.pop_front();
      rsp         = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = r.addr ^ 32'hFFFF_FFFF;
    end else if (k_stray && !k_reset) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      k_stray     = 1'b0;
    end

    #4;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_adel  = out_adel;
    if (imem_req && imem_gnt) dut_grants++;
    if (out_valid && !stall) dut_pops++;

    if (reset) begin
      check("req_in_reset", 32'(imem_req), 32'd0);
      mq.delete();
      mem_q.delete();
      epoch++;
      exp_req_pc  = RST_PC;
      halted_m    = 1'b0;
      after_reset = 1'b1;
    end else begin
      if (after_reset) begin
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_adel", 32'(out_adel), 32'd0);
        after_reset = 1'b0;
      end
      pend       = mem_q.size() + (rsp ? 1 : 0);
      ex_allowed = !halted_m && !redirect_valid && (pend + mq.size() < DEPTH);
      ex_req     = ex_allowed && (exp_req_pc[1:0] == 2'b00);
      ex_adel    = ex_allowed && (exp_req_pc[1:0] != 2'b00);
      check("imem_req", 32'(imem_req), 32'(ex_req));
      if (ex_req && imem_req) check("imem_addr", imem_addr, exp_req_pc);
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0 && out_valid) begin
        e = mq[0];
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("out_adel", 32'(out_adel), 32'(e.adel));
      end
      if (mq.size() != 0 && !stall) void'(mq.pop_front());
      if (ex_req && imem_gnt) begin
        mem_q.push_back('{addr: exp_req_pc, due: cyc + lat, epoch: epoch});
        exp_req_pc += 32'd4;
      end
      if (rsp && r.epoch == epoch)
        mq.push_back('{pc: r.addr, instr: r.addr ^ 32'hFFFF_FFFF, adel: 1'b0});
      if (ex_adel) begin
        mq.push_back('{pc: exp_req_pc, instr: 32'd0, adel: 1'b1});
        halted_m = 1'b1;
      end
      if (redirect_valid) begin
        mq.delete();
        epoch++;
        exp_req_pc = redirect_pc;
        halted_m   = 1'b0;
      end
    end
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset(input int unsigned n);
    k_reset = 1'b1;
    run_cycles(n);
    k_reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int unsigned limit);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      run_cycle();
      seen = s_valid;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    // Streaming with a 1-cycle memory and no stall
    k_lat = 1;
    do_reset(3);
    dut_pops = 0;
    run_cycle();
    check("a_req0", 32'(s_req), 32'd1);
    check("a_addr0", s_addr, RST_PC);
    run_cycles(19);
    check("a_pops", dut_pops, 32'd18);

    // Stall held from reset: credit fills, then resume at +16
    k_stall = 1'b1;
    do_reset(2);
    dut_grants = 0;
    run_cycles(10);
    check("b_grants", dut_grants, 32'd4);
    check("b_req_full", 32'(s_req), 32'd0);
    check("b_head", s_pc, RST_PC);
    k_stall = 1'b0;
    run_cycles(2);
    check("b_resume_req", 32'(s_req), 32'd1);
    check("b_resume_addr", s_addr, 32'hBFC0_0010);
    run_cycles(10);

    // Redirect with two late responses outstanding
    k_lat = 3;
    do_reset(2);
    run_cycles(2);
    k_redir = 1'b1; k_redir_pc = 32'h8000_0100;
    run_cycle();
    check("c_req_redir", 32'(s_req), 32'd0);
    wait_valid("c_wait", 20);
    check("c_pc", s_pc, 32'h8000_0100);
    check("c_instr", s_instr, 32'h7FFF_FEFF);

    // Redirect while a live response is arriving
    k_lat = 1;
    run_cycles(6);
    k_redir = 1'b1; k_redir_pc = 32'h8000_0200;
    run_cycle();
    wait_valid("d_wait", 20);
    check("d_pc", s_pc, 32'h8000_0200);

    // Misaligned redirect: AdEL entry then halt until the next redirect
    k_redir = 1'b1; k_redir_pc = 32'h8000_0102;
    run_cycle();
    wait_valid("e_wait", 20);
    check("e_adel", 32'(s_adel), 32'd1);
    check("e_pc", s_pc, 32'h8000_0102);
    check("e_instr", s_instr, 32'd0);
    run_cycles(6);
    check("e_halt_req", 32'(s_req), 32'd0);
    check("e_halt_valid", 32'(s_valid), 32'd0);
    k_redir = 1'b1; k_redir_pc = 32'h8000_0180;
    run_cycle();
    wait_valid("e_resume_wait", 20);
    check("e_resume_pc", s_pc, 32'h8000_0180);

    // Reset with full credit (2 buffered, 2 outstanding), then a stray rvalid
    k_lat = 3; k_stall = 1'b1;
    do_reset(2);
    run_cycles(5);
    do_reset(1);
    k_stall = 1'b0; k_stray = 1'b1;
    run_cycle();
    check("f_valid", 32'(s_valid), 32'd0);
    check("f_req", 32'(s_req), 32'd1);
    check("f_addr", s_addr, RST_PC);
    run_cycle();
    check("f_stray_valid", 32'(s_valid), 32'd0);
    run_cycles(15);

    // Randomized traffic: grant, latency, response gaps, stall, redirects
    k_lat = 0; k_gnt_rand = 1'b1; k_rsp_rand = 1'b1;
    k_stall_rand = 1'b1; k_redir_rand = 1'b1;
    run_cycles(1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
